mcif_wr_arbiter: RTL and testbench

- Shares the single MCIF write-request channel among N_REQ write DMAs (softmax_wdma and sibling wdma blocks).
- A requester is granted in round-robin order on a command beat. The grant stays locked until that burst's last data beat is accepted.
- Completion pulses from MCIF are routed back to the requester that issued the matching nonposted burst.
- Sits between the wdma blocks and the MCIF write port.

---
 rtl/mcif_wr_arbiter_pkg.sv | 35 +++
 rtl/mcif_tag_fifo.sv | 49 ++++
 rtl/mcif_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_mcif_wr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcif_wr_arbiter_pkg.sv
// Shared definitions for the MCIF write-request arbiter.
// Holds the payload field layout, default sizing and FSM state encoding.
package mcif_wr_arbiter_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int LEN_W_DEF     = 4;
    localparam int DAT_W_DEF     = 32;
    localparam int TAG_DEPTH_DEF = 4;

    localparam int ADDR_LSB = 0;
    localparam int LEN_LSB  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    function automatic int pd_width(input int len_w, input int dat_w);
        return 2 + len_w + 32 + dat_w;
    endfunction

    function automatic int nonposted_bit(input int len_w);
        return LEN_LSB + len_w;
    endfunction

    function automatic int cmd_flag_bit(input int pd_w);
        return pd_w - 1;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcif_tag_fifo.sv
// Small synchronous FIFO of requester ids for outstanding nonposted bursts.
// A pop frees its slot in the same cycle, so push+pop on a full FIFO is accepted.
module mcif_tag_fifo
    import mcif_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/mcif_wr_arbiter.sv
// Round-robin arbiter sharing the MCIF write-request channel between wdma blocks.
// Grants are locked for a whole burst; completions are routed back by issue order.
module mcif_wr_arbiter
    import mcif_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int DAT_W     = DAT_W_DEF,
    parameter int PD_W      = pd_width(LEN_W, DAT_W),
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_vld,
    output logic [N_REQ-1:0]      req_rdy,
    input  logic [N_REQ*PD_W-1:0] req_pd,
    output logic                  mcif_wr_req_vld,
    input  logic                  mcif_wr_req_rdy,
    output logic [PD_W-1:0]       mcif_wr_req_pd,
    input  logic                  mcif_wr_rsp_complete,
    output logic [N_REQ-1:0]      rsp_complete,
    output logic                  err_orphan
);

    localparam int ID_W          = id_width(N_REQ);
    localparam int CMD_FLAG_BIT  = cmd_flag_bit(PD_W);
    localparam int NONPOSTED_BIT = nonposted_bit(LEN_W);

    arb_state_e       r_state;
    logic [ID_W-1:0]  r_grant;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [LEN_W-1:0] r_len_q;
    logic             r_err_orphan;

    logic [PD_W-1:0]  w_pd [N_REQ];
    logic [N_REQ-1:0] w_elig;
    logic             w_found;
    logic [ID_W-1:0]  w_pick;
    logic [ID_W:0]    w_idx;
    logic             w_busy;
    logic             w_hs;
    logic             w_push;
    logic             w_pop;
    logic [ID_W-1:0]  w_head;
    logic             w_full;
    logic             w_empty;
    logic [ID_W-1:0]  w_rr_next;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign w_pd[g]   = req_pd[g*PD_W +: PD_W];
        assign w_elig[g] = req_vld[g] & w_pd[g][CMD_FLAG_BIT] &
                           ~(w_pd[g][NONPOSTED_BIT] & w_full);
    end

    // First eligible requester at or after the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_REQ)) w_idx = w_idx - (ID_W+1)'(N_REQ);
            if (!w_found && w_elig[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_busy = (r_state != ST_IDLE);

    always_comb begin
        mcif_wr_req_vld = 1'b0;
        mcif_wr_req_pd  = '0;
        req_rdy         = '0;
        if (w_busy) begin
            mcif_wr_req_vld  = req_vld[r_grant];
            mcif_wr_req_pd   = w_pd[r_grant];
            req_rdy[r_grant] = mcif_wr_req_rdy;
        end
    end

    assign w_hs   = mcif_wr_req_vld & mcif_wr_req_rdy;
    assign w_push = (r_state == ST_CMD) & w_hs & mcif_wr_req_pd[NONPOSTED_BIT];
    assign w_pop  = mcif_wr_rsp_complete & ~w_empty;

    assign rsp_complete = w_pop ? (N_REQ'(1) << w_head) : '0;
    assign err_orphan   = r_err_orphan;

    assign w_rr_next = (r_grant == ID_W'(N_REQ-1)) ? '0 : r_grant + 1'b1;

    mcif_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_grant),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_len_q      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            // A completion with nothing outstanding cannot be routed
            if (mcif_wr_rsp_complete & w_empty) r_err_orphan <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_hs) begin
                        r_len_q    <= mcif_wr_req_pd[LEN_LSB +: LEN_W];
                        r_beat_cnt <= '0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == r_len_q) begin
                            r_rr_ptr <= w_rr_next;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcif_wr_arbiter.sv
// Randomised bench for mcif_wr_arbiter against a burst-level reference model.
// Directed scenarios first, then a long random run, then a mid-burst reset.
module tb_mcif_wr_arbiter;

    localparam int N   = 4;
    localparam int LW  = 4;
    localparam int DW  = 32;
    localparam int TD  = 4;
    localparam int PW  = 2 + LW + 32 + DW;
    localparam int NPB = 32 + LW;

    typedef logic [PW-1:0] pd_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_rdy;
    logic [N*PW-1:0] req_pd;
    logic            mvld;
    logic            mrdy;
    logic [PW-1:0]   mpd;
    logic            cmp;
    logic [N-1:0]    rsp;
    logic            err;

    always #5 clk = ~clk;

    mcif_wr_arbiter #(
        .N_REQ     (N),
        .LEN_W     (LW),
        .DAT_W     (DW),
        .PD_W      (PW),
        .TAG_DEPTH (TD)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_vld              (req_vld),
        .req_rdy              (req_rdy),
        .req_pd               (req_pd),
        .mcif_wr_req_vld      (mvld),
        .mcif_wr_req_rdy      (mrdy),
        .mcif_wr_req_pd       (mpd),
        .mcif_wr_rsp_complete (cmp),
        .rsp_complete         (rsp),
        .err_orphan           (err)
    );

    pd_t rq [N][$];
    int  p_vld = 100;
    int  p_rdy = 100;
    bit  gen_en = 1'b0;

    int  m_owner;
    int  m_left;
    int  m_rr;
    bit  m_started;
    bit  m_err;
    int  m_tags [$];

    int           d_glog [$];
    logic [N-1:0] d_rsp;
    logic         d_err;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pd_t rnd_pd();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    task automatic add_burst(input int r, input bit np, input int len);
        pd_t p;
        p = rnd_pd();
        p[PW-1] = 1'b1;
        p[NPB] = np;
        p[32 +: LW] = LW'(len);
        rq[r].push_back(p);
        for (int b = 0; b <= len; b++) begin
            p = rnd_pd();
            p[PW-1] = 1'b0;
            rq[r].push_back(p);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_left = 0;
        m_rr = 0;
        m_started = 1'b0;
        m_err = 1'b0;
        m_tags.delete();
    endtask

    function automatic bit busy();
        bit b;
        b = (m_owner >= 0);
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic step(input bit cmp_in);
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rsp;
        logic         e_vld;
        pd_t          e_pd;
        pd_t          hd;
        bit           hs;
        int           idx;
        if (gen_en)
            for (int i = 0; i < N; i++)
                if (rq[i].size() == 0 && $urandom_range(3) == 0)
                    add_burst(i, 1'($urandom_range(1)), $urandom_range(15));
        for (int i = 0; i < N; i++) begin
            req_vld[i] = (rq[i].size() > 0) && ($urandom_range(99) < p_vld);
            req_pd[i*PW +: PW] = (rq[i].size() > 0) ? rq[i][0] : '0;
        end
        mrdy = ($urandom_range(99) < p_rdy);
        cmp = cmp_in;
        #3;
        e_vld = 1'b0;
        e_pd = '0;
        e_rdy = '0;
        if (m_owner >= 0) begin
            e_vld = req_vld[m_owner];
            e_pd = req_pd[m_owner*PW +: PW];
            e_rdy[m_owner] = mrdy;
        end
        e_rsp = (cmp_in && m_tags.size() > 0) ? (N'(1) << m_tags[0]) : '0;
        chk("mcif_vld", mvld, e_vld);
        chk("mcif_pd", mpd, e_pd);
        chk("req_rdy", req_rdy, e_rdy);
        chk("rsp_complete", rsp, e_rsp);
        chk("err_orphan", err, m_err);
        d_rsp = rsp;
        d_err = err;
        for (int i = 0; i < N; i++)
            if (req_rdy[i] && req_vld[i] && req_pd[i*PW+PW-1])
                d_glog.push_back(i);
        hs = e_vld && mrdy;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (req_vld[idx] && rq[idx][0][PW-1] &&
                    !(rq[idx][0][NPB] && m_tags.size() >= TD)) begin
                    m_owner = idx;
                    m_started = 1'b0;
                    break;
                end
            end
        end else if (hs) begin
            hd = rq[m_owner][0];
            if (!m_started) begin
                m_started = 1'b1;
                m_left = int'(hd[32 +: LW]) + 1;
            end else begin
                m_left--;
            end
        end
        if (cmp_in) begin
            if (m_tags.size() > 0) void'(m_tags.pop_front());
            else m_err = 1'b1;
        end
        if (hs && m_left == int'(hd[32 +: LW]) + 1 && hd[PW-1] && hd[NPB])
            m_tags.push_back(m_owner);
        if (hs && m_started && m_left == 0) begin
            m_rr = (m_owner + 1) % N;
            m_owner = -1;
        end
        for (int i = 0; i < N; i++)
            if (e_rdy[i] && req_vld[i]) void'(rq[i].pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int maxc, output int n);
        n = 0;
        while (busy() && n < maxc) begin
            step(1'b0);
            n++;
        end
        chk("idle_timeout", busy(), 1'b0);
    endtask

    task automatic drain(input int maxc);
        int g;
        g = 0;
        while ((busy() || m_tags.size() > 0) && g < maxc) begin
            step(m_tags.size() > 0);
            g++;
        end
        chk("drain_timeout", busy() || m_tags.size() > 0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        cmp = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        m_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int lim;
        rst = 1'b1;
        req_vld = '0;
        req_pd = '0;
        mrdy = 1'b0;
        cmp = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", mvld, 1'b0);
        chk("rst_rdy", req_rdy, '0);
        chk("rst_pd", mpd, '0);
        chk("rst_rsp", rsp, '0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;

        add_burst(0, 1'b1, 3);
        run_idle(20, n);
        chk("t1_cycles", n, 6);
        step(1'b1);
        chk("t1_rsp", d_rsp, 4'b0001);

        do_reset();
        add_burst(0, 1'b0, 0);
        add_burst(1, 1'b0, 0);
        add_burst(2, 1'b0, 0);
        add_burst(0, 1'b0, 0);
        d_glog.delete();
        run_idle(40, n);
        chk("t2_cycles", n, 12);
        chk("t2_ngrant", d_glog.size(), 4);
        if (d_glog.size() == 4) begin
            chk("t2_g0", d_glog[0], 0);
            chk("t2_g1", d_glog[1], 1);
            chk("t2_g2", d_glog[2], 2);
            chk("t2_g3", d_glog[3], 0);
        end

        p_rdy = 50;
        d_glog.delete();
        add_burst(0, 1'b0, 3);
        step(1'b0);
        step(1'b0);
        add_burst(1, 1'b0, 1);
        run_idle(100, n);
        chk("t3_ngrant", d_glog.size(), 2);
        if (d_glog.size() == 2) chk("t3_g1", d_glog[1], 1);

        p_rdy = 100;
        d_glog.delete();
        for (int b = 0; b < 6; b++) add_burst(2, 1'b1, 1);
        add_burst(3, 1'b0, 2);
        repeat (40) step(1'b0);
        chk("t4_blocked", d_glog.size(), 5);
        if (d_glog.size() >= 2) chk("t4_posted", d_glog[1], 3);
        step(1'b1);
        chk("t4_rsp", d_rsp, 4'b0100);
        repeat (10) step(1'b0);
        chk("t4_unblock", d_glog.size(), 6);
        drain(200);

        step(1'b1);
        chk("t5_rsp", d_rsp, '0);
        step(1'b0);
        chk("t5_err", d_err, 1'b1);
        repeat (3) step(1'b0);
        chk("t5_sticky", d_err, 1'b1);
        do_reset();
        step(1'b0);
        chk("t5_clear", d_err, 1'b0);

        gen_en = 1'b1;
        p_vld = 75;
        p_rdy = 70;
        for (int c = 0; c < 3000; c++)
            step(m_tags.size() > 0 ? ($urandom_range(4) == 0)
                                   : ($urandom_range(63) == 0));
        gen_en = 1'b0;
        drain(2000);

        p_vld = 100;
        p_rdy = 100;
        add_burst(0, 1'b0, 7);
        lim = 0;
        while (!(m_owner == 0 && m_started && m_left == 6) && lim < 20) begin
            step(1'b0);
            lim++;
        end
        chk("t6_reach", lim < 20, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_vld", mvld, 1'b0);
        chk("t6_rdy", req_rdy, '0);
        chk("t6_pd", mpd, '0);
        @(posedge clk);
        #1;
        chk("t6_vld_hold", mvld, 1'b0);
        chk("t6_rdy_hold", req_rdy, '0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        m_reset();
        d_glog.delete();
        add_burst(1, 1'b1, 2);
        run_idle(20, n);
        chk("t6_cycles", n, 5);
        chk("t6_ngrant", d_glog.size(), 1);
        step(1'b1);
        chk("t6_rsp", d_rsp, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
